// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmit buffer.
// The issue state machine lives in the top level; the FIFO is a separate block.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

  // Width of an index into n entries (never narrower than one bit).
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy needs one extra bit so that "completely full" is representable.
  function automatic int count_width(input int depth);
    return addr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count, decoded flags and
// a sticky overflow flag; read data is the entry at the read pointer.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  input  logic                          clr_flags,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          almost_full,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_COUNT   = CW'(ALMOST_FULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_accept;
  logic                  pop;

  assign full        = (count == FULL_COUNT);
  assign almost_full = (count >= AF_COUNT);
  assign empty       = (count == '0);

  // A write while full is dropped even if a pop frees a slot at the same edge.
  assign wr_accept = wr_en && !full;
  assign pop       = rd_en && !empty;
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              overflow <= 1'b0;
    else if (clr_flags)     overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART transmitter: queues host bytes and
// issues them one at a time, watching the transmitter's busy acknowledgement.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH        = 16,
  parameter int ALMOST_FULL_LEVEL = 12,
  parameter int BUSY_TIMEOUT      = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [INPUT_DATA_WIDTH-1:0]        wr_data,
  output logic                               full,
  output logic                               almost_full,
  output logic                               empty,
  output logic [count_width(FIFO_DEPTH)-1:0] fifo_count,
  output logic                               overflow,
  output logic                               tx_timeout,
  input  logic                               clr_flags,
  output logic                               tx_enable,
  output logic [INPUT_DATA_WIDTH-1:0]        tx_data,
  input  logic                               tx_busy
);

  localparam int TW = addr_width(BUSY_TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);

  // Handshake: tx_enable is a one-cycle issue carrying tx_data; the
  // transmitter acknowledges by raising tx_busy and finishes the frame when
  // tx_busy falls. A byte is issued only from IDLE while tx_busy is low, and
  // a transmitter that never raises tx_busy is abandoned after BUSY_TIMEOUT.
  tx_state_t                   state;
  tx_state_t                   state_next;
  logic [TW-1:0]               timer;
  logic [TW-1:0]               timer_next;
  logic                        issue;
  logic                        timeout_set;
  logic [INPUT_DATA_WIDTH-1:0] head_data;

  uart_sync_fifo #(
    .DATA_WIDTH       (INPUT_DATA_WIDTH),
    .DEPTH            (FIFO_DEPTH),
    .ALMOST_FULL_LEVEL(ALMOST_FULL_LEVEL)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (issue),
    .clr_flags  (clr_flags),
    .rd_data    (head_data),
    .full       (full),
    .almost_full(almost_full),
    .empty      (empty),
    .count      (fifo_count),
    .overflow   (overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  always_comb begin
    state_next  = state;
    timer_next  = timer;
    issue       = 1'b0;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          issue      = 1'b1;
          timer_next = '0;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer == TIMEOUT_LAST) begin
          // The byte is treated as sent; the queue keeps moving.
          timeout_set = 1'b1;
          state_next  = IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_enable <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_enable <= issue;
      if (issue) tx_data <= head_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            tx_timeout <= 1'b0;
    else if (clr_flags)   tx_timeout <= 1'b0;
    else if (timeout_set) tx_timeout <= 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small behavioural transmitter that
// answers each issue with a programmable busy delay and length.
module tb_uart_tx_fifo;

  localparam int W  = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          full, almost_full, empty, overflow, tx_timeout, tx_enable;
  logic [CW-1:0] fifo_count;
  logic          clr_flags = 1'b0;
  logic [W-1:0]  tx_data;
  logic          tx_busy;

  int errors = 0;
  int checks = 0;

  // transmitter model controls
  bit model_en   = 1'b0;
  bit force_busy = 1'b0;
  int busy_delay = 2;
  int busy_len   = 20;
  int mcnt       = 0;
  logic model_busy = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic prev_en = 1'b0;
  int   double_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .empty(empty),
    .fifo_count(fifo_count), .overflow(overflow), .tx_timeout(tx_timeout),
    .clr_flags(clr_flags), .tx_enable(tx_enable), .tx_data(tx_data),
    .tx_busy(tx_busy)
  );

  assign tx_busy = force_busy | model_busy;

  always @(posedge clk or posedge reset) begin
    if (reset || !model_en) begin
      mcnt       <= 0;
      model_busy <= 1'b0;
    end else if (tx_enable) begin
      mcnt       <= 1;
      model_busy <= 1'b0;
    end else if (mcnt != 0) begin
      model_busy <= (mcnt >= busy_delay - 1) && (mcnt < busy_delay - 1 + busy_len);
      mcnt       <= (mcnt >= busy_delay - 1 + busy_len) ? 0 : mcnt + 1;
    end
  end

  // Output monitor: every issued byte, plus any pulse longer than one cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_enable) got_q.push_back(tx_data);
      if (tx_enable && prev_en) double_cnt <= double_cnt + 1;
    end
    prev_en <= tx_enable;
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(empty && !tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(empty && !tx_busy)) begin
      errors++;
      $display("FAIL drain_timeout: count=%0d busy=%b after %0d cycles, required empty and idle", fifo_count, tx_busy, budget);
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({empty, full, almost_full, overflow, tx_timeout, tx_enable} !== 6'b100000 || fifo_count !== 5'd0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_in: flags=%b count=%0d data=%h, required 100000/0/00", {empty, full, almost_full, overflow, tx_timeout, tx_enable}, fifo_count, tx_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({empty, full, almost_full, overflow, tx_timeout, tx_enable} !== 6'b100000 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_out: flags=%b count=%0d, required 100000/0", {empty, full, almost_full, overflow, tx_timeout, tx_enable}, fifo_count);
    end
  endtask

  task automatic test_single();
    int base = got_q.size();
    model_en = 1'b1; busy_delay = 2; busy_len = 20;
    wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (fifo_count !== 5'd1 || tx_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_write: count=%0d en=%b, required 1/0", fifo_count, tx_enable);
    end
    @(negedge clk);
    checks++;
    if (tx_enable !== 1'b1 || tx_data !== 8'h55 || empty !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: en=%b data=%h empty=%b, required 1/55/1", tx_enable, tx_data, empty);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (got_q.size() !== base + 1 || tx_data !== 8'h55) begin
      errors++;
      $display("FAIL single_pulses: pulses=%0d data=%h, required 1/55", got_q.size() - base, tx_data);
    end
  endtask

  task automatic test_burst_full();
    int base = got_q.size();
    logic [CW-1:0] exp_cnt;
    exp_q.delete();
    model_en = 1'b0; force_busy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1; wr_data = 8'(k);
      exp_q.push_back(wr_data);
      @(negedge clk);
      exp_cnt = 5'(k + 1);
      checks++;
      if ({fifo_count, almost_full, full} !== {exp_cnt, (k + 1 >= 12), (k + 1 == 16)}) begin
        errors++;
        $display("FAIL burst_flags: count=%0d af=%b full=%b, required %0d/%b/%b", fifo_count, almost_full, full, exp_cnt, (k + 1 >= 12), (k + 1 == 16));
      end
    end
    wr_data = 8'hAA;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 5'd16) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b count=%0d, required 1/16", overflow, fifo_count);
    end
    clr_flags = 1'b1; wr_data = 8'hAC;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++;
    if (overflow !== 1'b0 || fifo_count !== 5'd16) begin
      errors++;
      $display("FAIL clr_priority: ovf=%b count=%0d, required 0/16", overflow, fifo_count);
    end
    force_busy = 1'b0; model_en = 1'b1; busy_delay = 2; busy_len = 3;
    wr_data = 8'hBB;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (fifo_count !== 5'd15 || overflow !== 1'b1 || tx_enable !== 1'b1 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL full_write_pop: count=%0d ovf=%b en=%b data=%h, required 15/1/1/00", fifo_count, overflow, tx_enable, tx_data);
    end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    wait_drain(400);
    checks++;
    if (got_q.size() !== base + 16) begin
      errors++;
      $display("FAIL burst_len: got %0d bytes, required 16", got_q.size() - base);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_q[base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL burst_order[%0d]: got %h, required %h", i, got_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_mid_write_pop();
    int base = got_q.size();
    exp_q.delete();
    model_en = 1'b0; force_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1; wr_data = 8'h20 + 8'(k);
      exp_q.push_back(wr_data);
      @(negedge clk);
    end
    checks++;
    if (fifo_count !== 5'd5) begin
      errors++;
      $display("FAIL mid_fill: count=%0d, required 5", fifo_count);
    end
    force_busy = 1'b0; model_en = 1'b1;
    wr_data = 8'h25;
    exp_q.push_back(wr_data);
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (fifo_count !== 5'd5 || tx_enable !== 1'b1 || tx_data !== 8'h20) begin
      errors++;
      $display("FAIL mid_write_pop: count=%0d en=%b data=%h, required 5/1/20", fifo_count, tx_enable, tx_data);
    end
    wait_drain(200);
    checks++;
    if (got_q.size() !== base + 6) begin
      errors++;
      $display("FAIL mid_len: got %0d bytes, required 6", got_q.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_q[base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL mid_order[%0d]: got %h, required %h", i, got_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int base = got_q.size();
    model_en = 1'b0; force_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h31;
    @(negedge clk);
    wr_data = 8'h32;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (tx_enable !== 1'b1 || tx_data !== 8'h31) begin
      errors++;
      $display("FAIL to_issue: en=%b data=%h, required 1/31", tx_enable, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_enable !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse_width: en=%b, required 0", tx_enable);
    end
    repeat (62) @(negedge clk);
    checks++;
    if (tx_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_early: timeout=%b at 63 cycles, required 0", tx_timeout);
    end
    @(negedge clk);
    checks++;
    if (tx_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_set: timeout=%b at 64 cycles, required 1", tx_timeout);
    end
    @(negedge clk);
    checks++;
    if (tx_enable !== 1'b1 || tx_data !== 8'h32) begin
      errors++;
      $display("FAIL to_next_issue: en=%b data=%h, required 1/32", tx_enable, tx_data);
    end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++;
    if (tx_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: timeout=%b, required 0", tx_timeout);
    end
    repeat (70) @(negedge clk);
    checks++;
    if (tx_timeout !== 1'b1 || got_q.size() !== base + 2) begin
      errors++;
      $display("FAIL to_second: timeout=%b pulses=%0d, required 1/2", tx_timeout, got_q.size() - base);
    end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int base;
    model_en = 1'b1; busy_delay = 2; busy_len = 20;
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1; wr_data = 8'h41 + 8'(k);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (fifo_count !== 5'd3 || tx_data !== 8'h41) begin
      errors++;
      $display("FAIL rst_pre: count=%0d data=%h, required 3/41", fifo_count, tx_data);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({empty, full, almost_full, overflow, tx_timeout, tx_enable} !== 6'b100000 || fifo_count !== 5'd0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: flags=%b count=%0d data=%h, required 100000/0/00", {empty, full, almost_full, overflow, tx_timeout, tx_enable}, fifo_count, tx_data);
    end
    @(negedge clk);
    reset = 1'b0;
    base = got_q.size();
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() !== base || empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_quiet: pulses=%0d empty=%b, required 0/1", got_q.size() - base, empty);
    end
    wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk);
    wr_en = 1'b0;
    wait_drain(100);
    checks++;
    if (got_q.size() !== base + 1 || got_q[got_q.size() - 1] !== 8'h77) begin
      errors++;
      $display("FAIL rst_resume: pulses=%0d last=%h, required 1/77", got_q.size() - base, got_q[got_q.size() - 1]);
    end
  endtask

  task automatic test_wrap();
    int sizes[6] = '{7, 12, 3, 9, 5, 4};
    int base = got_q.size();
    int n = 0;
    logic [CW-1:0] max_cnt = '0;
    exp_q.delete();
    model_en = 1'b1; force_busy = 1'b0; busy_delay = 2; busy_len = 2;
    foreach (sizes[b]) begin
      for (int i = 0; i < sizes[b]; i++) begin
        wr_en = 1'b1; wr_data = 8'((n * 37 + 11) & 255);
        exp_q.push_back(wr_data);
        n++;
        @(negedge clk);
        if (fifo_count > max_cnt) max_cnt = fifo_count;
      end
      wr_en = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (fifo_count > max_cnt) max_cnt = fifo_count;
      end
    end
    wait_drain(400);
    checks++;
    if (max_cnt > 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_bounds: max count=%0d ovf=%b, required <=16/0", max_cnt, overflow);
    end
    checks++;
    if (got_q.size() !== base + 40) begin
      errors++;
      $display("FAIL wrap_len: got %0d bytes, required 40", got_q.size() - base);
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (got_q[base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wrap_order[%0d]: got %h, required %h", i, got_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_full();
    test_mid_write_pop();
    test_timeout();
    test_reset_mid_frame();
    test_wrap();
    checks++;
    if (double_cnt !== 0) begin
      errors++;
      $display("FAIL pulse_width: %0d multi-cycle pulses, required 0", double_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer that sits directly upstream of the UART transmitter.
- Accepts bytes from the host at any rate, stores them in a synchronous FIFO, and drains them one at a time into the transmitter's enable/i_data/o_busy handshake.
- Removes the host's need to poll busy and prevents lost bytes when enable is pulsed mid-frame.

Parameters:
- INPUT_DATA_WIDTH, 8, byte width; must match the transmitter.
- FIFO_DEPTH, 16, entries; power of 2, ≥2.
- ALMOST_FULL_LEVEL, 12, count at or above which almost_full asserts.
- BUSY_TIMEOUT, 64, cycles to wait for the transmitter to raise busy after an issue.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  host write strobe
- wr_data  in  INPUT_DATA_WIDTH  host byte
- full  out  1  FIFO full
- almost_full  out  1  count ≥ ALMOST_FULL_LEVEL
- empty  out  1  count == 0
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy
- overflow  out  1  sticky: write attempted while full
- tx_timeout  out  1  sticky: transmitter never acknowledged an issue
- clr_flags  in  1  synchronous clear of overflow and tx_timeout
- tx_enable  out  1  one-cycle issue pulse to transmitter enable
- tx_data  out  INPUT_DATA_WIDTH  byte to transmitter i_data
- tx_busy  in  1  transmitter o_busy

Behaviour:
- Single clock domain.
- Reset (async assert) drives all of the following, regardless of state, including mid-frame; the transmitter is reset by the same signal:
  - pointers = 0, fifo_count = 0, empty = 1
  - full = 0, almost_full = 0
  - overflow = 0, tx_timeout = 0
  - tx_enable = 0, tx_data = 0
  - state = IDLE, timeout counter = 0
- Storage:
  - Circular buffer with ADDR_WIDTH = clog2(FIFO_DEPTH).
  - Pointers are ADDR_WIDTH wide and wrap modulo FIFO_DEPTH.
  - fifo_count is one bit wider than the pointers.
  - full/empty/almost_full are decoded from the registered fifo_count.
- Write:
  - Accepted when wr_en and !full, evaluated on pre-edge state.
  - wr_en while full drops the byte, leaves pointers unchanged, and sets overflow.
  - This holds even if a pop happens in the same cycle.
- Simultaneous accepted write and pop: fifo_count unchanged, both pointers advance.
- clr_flags has priority over a same-cycle set event.
- State machine:
  - IDLE: at an edge where !empty and !tx_busy:
    - register tx_enable = 1 and tx_data = mem[rd_ptr]
    - pop the entry (advance rd_ptr, decrement count)
    - go to WAIT_BUSY and clear the timeout counter
  - WAIT_BUSY:
    - tx_enable returns to 0 (pulse is exactly 1 cycle).
    - If tx_busy = 1, go to WAIT_DONE.
    - Otherwise increment the counter; when it reaches BUSY_TIMEOUT−1, set tx_timeout and return to IDLE (byte counted as sent).
  - WAIT_DONE: tx_busy = 0 -> IDLE.
  - Earliest next issue is the edge after returning to IDLE.
- tx_data is held stable from issue until the next issue.
- Latency:
  - Write accepted at edge N into an empty FIFO with transmitter idle -> tx_enable high in the cycle following edge N+1.
  - Back-to-back frames are separated by ≥1 idle cycle after busy falls.
- If tx_busy is already high in IDLE (external activity), no issue occurs until it falls.
- Bytes leave in strict write order; none are duplicated or reordered.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, WAIT_BUSY, WAIT_DONE}
  - INPUT_DATA_WIDTH default
  - clog2-derived width helpers
- One sub-module, uart_sync_fifo: memory, pointers, count, flags, overflow.
- Top level holds the issue FSM and timeout counter.

Test Plan:
- Write 0x55 into an empty FIFO; tx_busy model rises 2 cycles after enable and stays high for 20 cycles -> exactly one tx_enable pulse with tx_data = 0x55; empty = 1 after the pop; no second pulse.
- Burst-write 0x00..0x0F (16 bytes) back-to-back while tx_busy is held high -> full = 1 at count 16; almost_full from count 12; the 17th write (0xAA) sets overflow; drained order is 0x00..0x0F.
- Simultaneous wr_en and pop at count 16 -> write dropped, overflow = 1, count = 15; at count 5 with write + pop -> count stays 5.
- tx_busy never asserts after an issue -> tx_timeout = 1 exactly BUSY_TIMEOUT cycles after the pulse; FSM returns to IDLE and issues the next byte; clr_flags clears tx_timeout next cycle.
- Assert reset during WAIT_DONE with 3 bytes queued -> all outputs take reset values immediately; after release, no tx_enable until a new write.
- Pointer wrap: write/drain 40 bytes in mixed bursts with DEPTH = 16 -> output sequence matches input exactly and count never exceeds 16.
